// File: rtl/mem_access_unit_if.sv
// Data-memory port between mem_access_unit (master) and the data memory (slave).
// Handshake: the master holds req=1 with stable addr/we/be/wdata until the slave
// returns a one-cycle ack pulse; rdata is only meaningful in the ack cycle.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack transaction per load or store, stalling the pipeline meanwhile.
// Optional feature: define MISALIGN_CHECK_EN to trap misaligned half/word accesses without touching memory.
module mem_access_unit (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        Funct3_i,
  input  logic [31:0]       Addr_i,
  input  logic [31:0]       WriteData_i,
  mem_access_unit_if.master dmem,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       ReadData_o,
  output logic              misalign_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic        access;
  logic        misalign;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Read+write together is treated as a store.
  assign access = valid_i & (MemRead_i | MemWrite_i);

`ifdef MISALIGN_CHECK_EN
  assign misalign = ((Funct3_i[1:0] == 2'b01) & Addr_i[0]) |
                    ((Funct3_i[1:0] == 2'b10) & (Addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // State register plus the latched request / result fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'h0;
      off_q   <= 2'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (access) state_d = misalign ? S_DONE : S_REQ;
      S_REQ:   if (dmem.ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_byte = 8'h0;
    case (off_q)
      2'd0: load_byte = dmem.rdata[7:0];
      2'd1: load_byte = dmem.rdata[15:8];
      2'd2: load_byte = dmem.rdata[23:16];
      2'd3: load_byte = dmem.rdata[31:24];
      default: load_byte = 8'h0;
    endcase
    load_half = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = dmem.rdata;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    if ((state_q == S_IDLE) && access) begin
      addr_d = {Addr_i[31:2], 2'b00};
      f3_d   = Funct3_i;
      off_d  = Addr_i[1:0];
      we_d   = MemWrite_i;
      mis_d  = misalign;
      if (misalign) rdata_d = 32'h0;
      if (MemWrite_i) begin
        case (Funct3_i)
          3'b000: begin
            be_d    = 4'b0001 << Addr_i[1:0];
            wdata_d = {4{WriteData_i[7:0]}};
          end
          3'b001: begin
            be_d    = Addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{WriteData_i[15:0]}};
          end
          default: begin
            be_d    = 4'b1111;
            wdata_d = WriteData_i;
          end
        endcase
      end else begin
        be_d    = 4'b1111;
        wdata_d = 32'h0;
      end
    end
    // Stores report zero so MEM/WB never captures stale load data for them.
    if ((state_q == S_REQ) && dmem.ack) rdata_d = we_q ? 32'h0 : load_data;
    if (state_q == S_DONE) mis_d = 1'b0;
  end

  always_comb begin
    stall_o  = 1'b0;
    done_o   = 1'b0;
    dmem.req = 1'b0;
    case (state_q)
      S_IDLE: stall_o = access;
      S_REQ: begin
        stall_o  = 1'b1;
        dmem.req = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.be     = be_q;
  assign dmem.wdata  = wdata_q;
  assign ReadData_o  = rdata_q;
  assign dbg_state_o = state_q;
`ifdef MISALIGN_CHECK_EN
  assign misalign_o  = mis_q;
`else
  assign misalign_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives the pipeline side and plays the data memory.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
module tb_mem_access_unit;
  logic        clk;
  logic        rst;
  logic        valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        stall;
  logic        done;
  logic [31:0] read_data;
  logic        misalign;
  logic [1:0]  dbg_state;

  mem_access_unit_if dmem ();

  mem_access_unit dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .MemRead_i   (mem_read),
    .MemWrite_i  (mem_write),
    .Funct3_i    (f3),
    .Addr_i      (addr),
    .WriteData_i (wdata_in),
    .dmem        (dmem.master),
    .stall_o     (stall),
    .done_o      (done),
    .ReadData_o  (read_data),
    .misalign_o  (misalign),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int          obs_stall;
  int          obs_req_cycles;
  int          obs_done_cycle;
  logic        obs_stable;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_we;
  logic [31:0] obs_rdata;
  logic        obs_mis;

  // Runs one access from IDLE (entered at edge+1) and records what was seen; returns at edge+1 in IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3_v,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_delay, input logic [31:0] mem_word);
    obs_stall = 0; obs_req_cycles = 0; obs_done_cycle = -1; obs_stable = 1'b1;
    obs_addr = 32'h0; obs_be = 4'h0; obs_wdata = 32'h0; obs_we = 1'b0;
    obs_rdata = 32'h0; obs_mis = 1'b0;
    valid = 1'b1; mem_read = rd; mem_write = wr; f3 = f3_v; addr = a; wdata_in = wd;
    for (int cyc = 0; cyc < 32; cyc++) begin
      #1;
      if (stall) obs_stall++;
      if (dmem.req) begin
        if (obs_req_cycles == 0) begin
          obs_addr = dmem.addr; obs_be = dmem.be; obs_wdata = dmem.wdata; obs_we = dmem.we;
        end else if ({dmem.addr, dmem.be, dmem.wdata, dmem.we} !== {obs_addr, obs_be, obs_wdata, obs_we}) begin
          obs_stable = 1'b0;
        end
        dmem.ack   = (obs_req_cycles == ack_delay);
        dmem.rdata = dmem.ack ? mem_word : 32'h0;
        obs_req_cycles++;
      end else begin
        dmem.ack = 1'b0; dmem.rdata = 32'h0;
      end
      if (done) begin
        obs_done_cycle = cyc; obs_rdata = read_data; obs_mis = misalign;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    dmem.ack = 1'b0;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    f3 = 3'b000; addr = 32'h0; wdata_in = 32'h0; dmem.ack = 1'b0; dmem.rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if ({dmem.req, dmem.we, done, misalign, stall} !== 5'b0)
      $display("FAIL reset_ctrl: got req/we/done/mis/stall=%b exp 00000", {dmem.req, dmem.we, done, misalign, stall}); else passed++;
    checks++; if ({dmem.addr, dmem.be, dmem.wdata, read_data} !== 100'h0)
      $display("FAIL reset_data: got addr=%h be=%h wdata=%h rd=%h exp all zero", dmem.addr, dmem.be, dmem.wdata, read_data); else passed++;
    checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else passed++;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    checks++; if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0)
      $display("FAIL lw_fields: got addr=%h be=%h we=%b exp 00000100 f 0", obs_addr, obs_be, obs_we); else passed++;
    checks++; if (obs_stall !== 2) $display("FAIL lw_stall: got %0d exp 2", obs_stall); else passed++;
    checks++; if (obs_done_cycle !== 2) $display("FAIL lw_done_cycle: got %0d exp 2", obs_done_cycle); else passed++;
    checks++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h exp deadbeef", obs_rdata); else passed++;
    checks++; if (read_data !== 32'hDEADBEEF || done !== 1'b0)
      $display("FAIL lw_hold: got rd=%h done=%b exp deadbeef 0", read_data, done); else passed++;
  endtask

  task automatic test_lb_lbu();
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFFFF);
    checks++; if (obs_rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata: got %h exp ffffff80", obs_rdata); else passed++;
    checks++; if (obs_addr !== 32'h100) $display("FAIL lb_addr: got %h exp 00000100", obs_addr); else passed++;
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FFFFFF);
    checks++; if (obs_rdata !== 32'h00000080) $display("FAIL lbu_rdata: got %h exp 00000080", obs_rdata); else passed++;
  endtask

  task automatic test_lh_lhu();
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80017FFF);
    checks++; if (obs_rdata !== 32'hFFFF8001) $display("FAIL lh_hi: got %h exp ffff8001", obs_rdata); else passed++;
    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80017FFF);
    checks++; if (obs_rdata !== 32'h00008001) $display("FAIL lhu_hi: got %h exp 00008001", obs_rdata); else passed++;
    run_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h80017FFF);
    checks++; if (obs_rdata !== 32'h00007FFF) $display("FAIL lh_lo: got %h exp 00007fff", obs_rdata); else passed++;
  endtask

  // Ack in the fourth REQ cycle: four REQ cycles plus the detect cycle stall the pipeline.
  task automatic test_sh_wait();
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 3, 32'hFFFFFFFF);
    checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_we !== 1'b1 || obs_addr !== 32'h100)
      $display("FAIL sh_fields: got be=%b wdata=%h we=%b addr=%h exp 1100 abcdabcd 1 00000100", obs_be, obs_wdata, obs_we, obs_addr); else passed++;
    checks++; if (obs_req_cycles !== 4 || obs_stable !== 1'b1)
      $display("FAIL sh_req_stable: got cycles=%0d stable=%b exp 4 1", obs_req_cycles, obs_stable); else passed++;
    checks++; if (obs_stall !== 5 || obs_done_cycle !== 5)
      $display("FAIL sh_stall: got stall=%0d done_cycle=%0d exp 5 5", obs_stall, obs_done_cycle); else passed++;
    checks++; if (obs_rdata !== 32'h0) $display("FAIL sh_rdata: got %h exp 00000000", obs_rdata); else passed++;
  endtask

  task automatic test_sb_sw();
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 0, 32'h0);
    checks++; if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5 || obs_addr !== 32'h200)
      $display("FAIL sb_fields: got be=%b wdata=%h addr=%h exp 0010 a5a5a5a5 00000200", obs_be, obs_wdata, obs_addr); else passed++;
    run_access(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 1, 32'h0);
    checks++; if (obs_be !== 4'b1111 || obs_wdata !== 32'hCAFEF00D || obs_we !== 1'b1)
      $display("FAIL sw_fields: got be=%b wdata=%h we=%b exp 1111 cafef00d 1", obs_be, obs_wdata, obs_we); else passed++;
    run_access(1'b1, 1'b1, 3'b010, 32'h40, 32'h01020304, 0, 32'h55555555);
    checks++; if (obs_we !== 1'b1 || obs_rdata !== 32'h0 || obs_wdata !== 32'h01020304)
      $display("FAIL rw_is_store: got we=%b rd=%h wdata=%h exp 1 00000000 01020304", obs_we, obs_rdata, obs_wdata); else passed++;
  endtask

  task automatic test_reset_in_req();
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; f3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    checks++; if (dmem.req !== 1'b1) $display("FAIL rreq_enter: got req=%b exp 1", dmem.req); else passed++;
    #2; rst = 1'b1; valid = 1'b0; mem_read = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || stall !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL rreq_abort: got req=%b stall=%b state=%0d exp 0 0 0", dmem.req, stall, dbg_state); else passed++;
    rst = 1'b0; dmem.ack = 1'b1; dmem.rdata = 32'h77777777;
    @(posedge clk); #1; dmem.ack = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || done !== 1'b0 || dmem.req !== 1'b0 || read_data !== 32'h0)
      $display("FAIL rreq_ack_idle: got state=%0d done=%b req=%b rd=%h exp 0 0 0 00000000", dbg_state, done, dmem.req, read_data); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h12345678);
`ifdef MISALIGN_CHECK_EN
    checks++; if (obs_req_cycles !== 0 || obs_done_cycle !== 1 || obs_mis !== 1'b1 || obs_rdata !== 32'h0)
      $display("FAIL misalign_trap: got req_cycles=%0d done_cycle=%0d mis=%b rd=%h exp 0 1 1 00000000", obs_req_cycles, obs_done_cycle, obs_mis, obs_rdata); else passed++;
    checks++; if (misalign !== 1'b0) $display("FAIL misalign_clear: got %b exp 0", misalign); else passed++;
`else
    checks++; if (obs_addr !== 32'h100 || obs_done_cycle !== 2 || obs_mis !== 1'b0 || obs_rdata !== 32'h12345678)
      $display("FAIL misalign_off: got addr=%h done_cycle=%0d mis=%b rd=%h exp 00000100 2 0 12345678", obs_addr, obs_done_cycle, obs_mis, obs_rdata); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    int nreq;
    int ndone;
    int done_cyc [2];
    logic [31:0] done_rd [2];
    logic [31:0] req_addr [2];
    nreq = 0; ndone = 0;
    done_cyc[0] = -1; done_cyc[1] = -1; done_rd[0] = 32'h0; done_rd[1] = 32'h0;
    req_addr[0] = 32'h0; req_addr[1] = 32'h0;
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; f3 = 3'b010; addr = 32'h200;
    for (int cyc = 0; cyc < 16; cyc++) begin
      #1;
      if (dmem.req) begin
        if (nreq < 2) req_addr[nreq] = dmem.addr;
        nreq++;
        dmem.ack = 1'b1;
        dmem.rdata = (dmem.addr == 32'h200) ? 32'h11111111 : 32'h22222222;
      end else begin
        dmem.ack = 1'b0;
      end
      if (done) begin
        if (ndone < 2) begin done_cyc[ndone] = cyc; done_rd[ndone] = read_data; end
        ndone++;
        if (ndone == 1) addr = 32'h204;
        else begin valid = 1'b0; mem_read = 1'b0; break; end
      end
      @(posedge clk); #1;
    end
    dmem.ack = 1'b0; valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (nreq !== 2 || req_addr[0] !== 32'h200 || req_addr[1] !== 32'h204)
      $display("FAIL b2b_reqs: got n=%0d a0=%h a1=%h exp 2 00000200 00000204", nreq, req_addr[0], req_addr[1]); else passed++;
    checks++; if (done_cyc[0] !== 2 || done_cyc[1] !== 5)
      $display("FAIL b2b_done_cycles: got %0d %0d exp 2 5", done_cyc[0], done_cyc[1]); else passed++;
    checks++; if (done_rd[0] !== 32'h11111111 || done_rd[1] !== 32'h22222222)
      $display("FAIL b2b_rdata: got %h %h exp 11111111 22222222", done_rd[0], done_rd[1]); else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_lh_lhu();
    test_sh_wait();
    test_sb_sw();
    test_reset_in_req();
    test_misalign();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
